// File: rtl/reg_bank_n_pkg.sv
// Shared definitions for the reg_bank_n scratch register file: opcodes, states
// and the opcode field width used to lay out the instruction word.
package reg_bank_n_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDI = 4'd1,
    OP_RDO = 4'd2,
    OP_MOV = 4'd3,
    OP_INC = 4'd4,
    OP_DEC = 4'd5,
    OP_CLR = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/reg_bank_n.sv
// Instruction-driven scratch register file: Count registers of Width bits,
// with a registered read-out port and a sticky error state on bad opcodes.
module reg_bank_n
  import reg_bank_n_pkg::*;
#(
  parameter int Width = 8,
  parameter int Count = 4,
  parameter int IdxW  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [OPCODE_W+IdxW+Width-1:0] inst,
  input  logic                           inst_en,
  output logic [Width-1:0]               out,
  output logic                           error
);

  // Count must be exactly 2**IdxW so every idx field value names a register.
  if ((Count < 2) || ((1 << IdxW) != Count)) begin : g_bad_cfg
    $error("reg_bank_n: Count must be a power of two >= 2 and equal 2**IdxW");
  end

  state_e           state_r, state_nxt_s;
  logic [Width-1:0] regs_r     [Count];
  logic [Width-1:0] regs_nxt_s [Count];
  logic [Width-1:0] out_r, out_nxt_s;
  logic             error_r, error_nxt_s;

  opcode_e          opcode_s;
  logic [IdxW-1:0]  idx_s;
  logic [Width-1:0] imm_s;
  logic [IdxW-1:0]  src_s;

  assign opcode_s = opcode_e'(inst[OPCODE_W+IdxW+Width-1 -: OPCODE_W]);
  assign idx_s    = inst[IdxW+Width-1 -: IdxW];
  assign imm_s    = inst[Width-1:0];
  assign src_s    = imm_s[IdxW-1:0];

  // Next-state / execute: all reads use pre-edge register values (no bypass).
  always_comb begin
    state_nxt_s = state_r;
    regs_nxt_s  = regs_r;
    out_nxt_s   = out_r;
    case (state_r)
      ST_RESET: begin
        state_nxt_s = ST_READY;
      end
      ST_READY: begin
        if (inst_en) begin
          case (opcode_s)
            OP_NOP: ;
            OP_LDI: regs_nxt_s[idx_s] = imm_s;
            OP_RDO: out_nxt_s = regs_r[idx_s];
            OP_MOV: regs_nxt_s[idx_s] = regs_r[src_s];
            OP_INC: regs_nxt_s[idx_s] = regs_r[idx_s] + Width'(1'b1);
            OP_DEC: regs_nxt_s[idx_s] = regs_r[idx_s] - Width'(1'b1);
            OP_CLR: begin
              for (int i = 0; i < Count; i++) begin
                regs_nxt_s[i] = {Width{1'b0}};
              end
            end
            default: begin
              state_nxt_s = ST_ERROR;
              out_nxt_s   = {Width{1'b0}};
            end
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ERROR: begin
        out_nxt_s = {Width{1'b0}};
      end
      default: begin
        state_nxt_s = ST_RESET;
      end
    endcase
    error_nxt_s = (state_nxt_s == ST_ERROR);
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_RESET;
      out_r   <= {Width{1'b0}};
      error_r <= 1'b0;
      for (int i = 0; i < Count; i++) begin
        regs_r[i] <= {Width{1'b0}};
      end
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
      error_r <= error_nxt_s;
      for (int i = 0; i < Count; i++) begin
        regs_r[i] <= regs_nxt_s[i];
      end
    end
  end

  assign out   = out_r;
  assign error = error_r;

endmodule

// File: doc/reg_bank_n.md
Name: reg_bank_n

Overview:
- Parametrised successor to the two-register instruction-driven bank: Count registers of Width bits.
- Driven by an opcode/index/immediate instruction word with an enable.
- Adds register-to-register move, increment/decrement, global clear and a sticky error state with a visible flag.
- Sits behind an instruction sequencer as a small scratch register file; its registered output feeds downstream datapath blocks.

Parameters:
- Width, 8, data width of each register and of out.
- Count, 4, number of registers; power of two, minimum 2.
- IdxW, 2, index field width; must equal log2(Count).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst  in  4+IdxW+Width  instruction, laid out as {opcode[3:0], idx[IdxW-1:0], imm[Width-1:0]}.
- inst_en  in  1  instruction valid; inst is ignored when low.
- out  out  Width  registered read-out value.
- error  out  1  high while the block is in the Error state.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high. reset high at a rising edge forces:
  - state=Reset, all registers=0, out=0, error=0.
  - reset has priority over everything, including in Error and mid-instruction.
- States:
  - Reset -> Ready on the first edge with reset low. inst is ignored on that edge.
  - Ready: executes one instruction per edge when inst_en=1.
  - Error: entered from Ready on an undefined opcode with inst_en=1. Sticky until reset; all instructions are ignored.
- Opcodes (4-bit):
  - NOP=0: no change.
  - LDI=1: reg[idx] <= imm.
  - RDO=2: out <= reg[idx], a snapshot; out holds until the next RDO or reset.
  - MOV=3: reg[idx] <= reg[imm[IdxW-1:0]]; upper imm bits are ignored. MOV with idx equal to source is a no-op.
  - INC=4: reg[idx] <= reg[idx]+1, modulo 2^Width (all-ones wraps to 0).
  - DEC=5: reg[idx] <= reg[idx]-1, modulo 2^Width (0 wraps to all-ones).
  - CLR=6: all registers <= 0; out unchanged.
  - 7..15: undefined; go to Error.
- Latency:
  - Register writes take effect at the sampling edge and are visible to an instruction on the next edge.
  - RDO updates out at its sampling edge, so out is valid one cycle after the instruction is presented.
  - No bypass: each instruction reads register values as they stood before its own edge.
- inst_en=0: no state, register or out change, even if opcode is undefined (no error).
- Error state:
  - On entry, error=1 from the entering edge and out is forced to 0.
  - Register contents are frozen, not cleared, until reset.
- Index range: idx is always in range because Count is a power of two. A non-power-of-two Count is a configuration error, flagged in elaboration.

Decomposition:
- Shared definitions include file (reg_bank_n_defs) holds:
  - opcode constants RegBankN_NOP/LDI/RDO/MOV/INC/DEC/CLR;
  - state constants Reset/Ready/Error;
  - field-slicing macros for opcode/idx/imm.
- These definitions are reused by the sequencer and the bench.
- No sub-module: storage is a Count-deep register array inside the block. The next-state/execute logic is a single case on the state and the opcode.

Test Plan:
- Reset, then LDI idx0 imm 8'hAE; RDO idx0 -> out=8'hAE one edge after RDO; error=0.
- LDI idx3 8'hFF; INC idx3; RDO idx3 -> out=8'h00 (wrap). Then DEC idx3; RDO idx3 -> out=8'hFF.
- LDI idx1 8'h5A; MOV idx2 <- src1; RDO idx2 -> out=8'h5A. Then CLR; RDO idx1 -> out=8'h00, while out held 8'h5A until that RDO.
- LDI idx2 8'h87 with inst_en=0; RDO idx2 -> out=8'h00 (write suppressed).
- Opcode 4'hF with inst_en=0 -> no error. Opcode 4'hF with inst_en=1 -> error=1, out=0. Subsequent LDI idx0 8'h27 and RDO are ignored; out stays 0.
- Assert reset 2 cycles while in Error:
  - registers=0, error=0, out=0;
  - the first instruction after deassert is ignored (Reset->Ready);
  - LDI idx0 8'h1A then RDO idx0 -> out=8'h1A.
- Repeat the first two scenarios with Width=16, Count=8: LDI idx7 16'hBEEF, RDO -> out=16'hBEEF.
